bidir_pad_ctrl: RTL

//   Core-to-pad driver for the bidir pad bank. It is the outbound complement of the pad ring's PAD2CORE inputs.
//   A 3-wire serial config port (sck/sdi/cs_n, taken from input pads) is synchronised into clk.
//   16-bit frames are decoded and committed to registered A/OE/CS/SL/IE/PU/PD drives for every bidir pad.

---
 rtl/pad_ctrl_pkg.sv | 18 +
 rtl/pad_sync.sv | 29 ++
 rtl/bidir_pad_ctrl.sv | 106 ++++++++++
 3 files changed

// File: rtl/pad_ctrl_pkg.sv
// pad_ctrl_pkg: shared frame layout, opcodes, cfg bit positions, reset values and FSM states
package pad_ctrl_pkg;
  localparam int FRAME_W = 16;
  typedef enum logic [1:0] {OP_OUT, OP_OE, OP_CFG, OP_RSVD} op_e;
  localparam int CFG_CS = 0;
  localparam int CFG_SL = 1;
  localparam int CFG_IE = 2;
  localparam int CFG_PU = 3;
  localparam int CFG_PD = 4;
  localparam logic RST_OUT = 1'b0;
  localparam logic RST_OE  = 1'b0;
  localparam logic RST_CS  = 1'b0;
  localparam logic RST_SL  = 1'b0;
  localparam logic RST_IE  = 1'b1;
  localparam logic RST_PU  = 1'b0;
  localparam logic RST_PD  = 1'b0;
  typedef enum logic {IDLE, SHIFT} state_e;
endpackage

// File: rtl/pad_sync.sv
// pad_sync: synchroniser chain (clk, rst, i_d in; o_lvl, o_rise, o_fall out) with registered edge pulses
module pad_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_lvl,
  output logic o_rise,
  output logic o_fall
);
  logic [STAGES-1:0] r_s;
  logic              r_dly;
  assign o_lvl = r_s[STAGES-1];
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s    <= {STAGES{RST_VAL}};
      r_dly  <= RST_VAL;
      o_rise <= 1'b0;
      o_fall <= 1'b0;
    end else begin
      r_s    <= {r_s[STAGES-2:0], i_d};
      r_dly  <= r_s[STAGES-1];
      o_rise <= r_s[STAGES-1] & ~r_dly;
      o_fall <= ~r_s[STAGES-1] & r_dly;
    end
  end
endmodule

// File: rtl/bidir_pad_ctrl.sv
// bidir_pad_ctrl: serial-configured registered drives (out/oe/cs/sl/ie/pu/pd) for the bidir pad bank, with frame_ok/frame_err pulses
module bidir_pad_ctrl
  import pad_ctrl_pkg::*;
#(
  parameter int NUM_BIDIR_PADS = 8,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cfg_sck_i,
  input  logic                      cfg_sdi_i,
  input  logic                      cfg_csn_i,
  output logic [NUM_BIDIR_PADS-1:0] bidir_out,
  output logic [NUM_BIDIR_PADS-1:0] bidir_oe,
  output logic [NUM_BIDIR_PADS-1:0] bidir_cs,
  output logic [NUM_BIDIR_PADS-1:0] bidir_sl,
  output logic [NUM_BIDIR_PADS-1:0] bidir_ie,
  output logic [NUM_BIDIR_PADS-1:0] bidir_pu,
  output logic [NUM_BIDIR_PADS-1:0] bidir_pd,
  output logic                      frame_ok,
  output logic                      frame_err
);
  localparam int N = NUM_BIDIR_PADS;
  logic w_sck_lvl, w_sck_rise, w_sck_fall;
  logic w_sdi_lvl, w_sdi_rise, w_sdi_fall;
  logic w_csn_lvl, w_csn_rise, w_csn_fall;
  logic w_unused;
  state_e r_state, w_next;
  logic [6:0] r_cnt;
  logic [FRAME_W-1:0] r_shreg;
  logic [7:0] r_warm;
  logic r_armed;
  logic w_start, w_end, w_shift, w_ok;
  op_e w_op;
  logic [5:0] w_idx;
  logic [7:0] w_data;
  pad_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck (
    .clk(clk), .rst(rst), .i_d(cfg_sck_i), .o_lvl(w_sck_lvl), .o_rise(w_sck_rise), .o_fall(w_sck_fall));
  pad_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sdi (
    .clk(clk), .rst(rst), .i_d(cfg_sdi_i), .o_lvl(w_sdi_lvl), .o_rise(w_sdi_rise), .o_fall(w_sdi_fall));
  pad_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_csn (
    .clk(clk), .rst(rst), .i_d(cfg_csn_i), .o_lvl(w_csn_lvl), .o_rise(w_csn_rise), .o_fall(w_csn_fall));
  assign w_unused = &{w_sck_lvl, w_sck_fall, w_sdi_rise, w_sdi_fall};
  assign w_op   = op_e'(r_shreg[15:14]);
  assign w_idx  = r_shreg[13:8];
  assign w_data = r_shreg[7:0];
  always_comb begin
    w_start = r_state == IDLE && w_csn_fall && r_armed;
    w_end   = r_state == SHIFT && w_csn_rise;
    w_shift = r_state == SHIFT && w_sck_rise && !w_csn_rise;
    w_ok    = w_end && r_cnt == 7'd16;
    w_next  = w_start ? SHIFT : w_end ? IDLE : r_state;
  end
  always_ff @(posedge clk) begin
    r_state <= rst ? IDLE : w_next;
  end
  // The reset-idle cs_n=1 in the sync chain is not a real observation; only
  // arm frame starts once a genuinely sampled high level has been seen.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_warm  <= '0;
      r_armed <= 1'b0;
    end else begin
      r_warm  <= (r_warm == 8'(SYNC_STAGES)) ? r_warm : r_warm + 8'd1;
      r_armed <= r_armed | (r_warm == 8'(SYNC_STAGES) && w_csn_lvl);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_shreg   <= '0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      bidir_out <= {N{RST_OUT}};
      bidir_oe  <= {N{RST_OE}};
      bidir_cs  <= {N{RST_CS}};
      bidir_sl  <= {N{RST_SL}};
      bidir_ie  <= {N{RST_IE}};
      bidir_pu  <= {N{RST_PU}};
      bidir_pd  <= {N{RST_PD}};
    end else begin
      frame_ok  <= w_ok;
      frame_err <= w_end && !w_ok;
      if (w_start) begin
        r_cnt   <= '0;
        r_shreg <= '0;
      end else if (w_shift) begin
        r_shreg <= {r_shreg[FRAME_W-2:0], w_sdi_lvl};
        r_cnt   <= (r_cnt == 7'd17) ? r_cnt : r_cnt + 7'd1;
      end
      if (w_ok) begin
        for (int p = 0; p < N; p++) begin
          if (w_op == OP_OUT && w_idx == 6'(p >> 3)) bidir_out[p] <= w_data[p[2:0]];
          if (w_op == OP_OE && w_idx == 6'(p >> 3)) bidir_oe[p] <= w_data[p[2:0]];
          if (w_op == OP_CFG && w_idx == 6'(p)) begin
            bidir_cs[p] <= w_data[CFG_CS];
            bidir_sl[p] <= w_data[CFG_SL];
            bidir_ie[p] <= w_data[CFG_IE];
            bidir_pu[p] <= w_data[CFG_PU];
            bidir_pd[p] <= w_data[CFG_PD] & ~w_data[CFG_PU];
          end
        end
      end
    end
  end
endmodule
